// File: rtl/branch_resolve_unit_if.sv
// Issue/result bus of the branch resolve unit.
//   in_*  : op from issue (valid/ready), operands, fetch prediction, ROB tag
//   out_* : resolved result to writeback/redirect (valid/ready)
// master = issue/writeback side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [2:0]       in_cmp;
   logic [XLEN-1:0]  in_pc;
   logic [XLEN-1:0]  in_rs1;
   logic [XLEN-1:0]  in_rs2;
   logic [XLEN-1:0]  in_imm;
   logic             in_pred_taken;
   logic [XLEN-1:0]  in_pred_target;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic             out_taken;
   logic [XLEN-1:0]  out_next_pc;
   logic [XLEN-1:0]  out_link;
   logic             out_mispredict;
   logic             out_misaligned;

   modport master (
      output in_valid, in_op, in_cmp, in_pc, in_rs1, in_rs2, in_imm,
             in_pred_taken, in_pred_target, in_tag, out_ready,
      input  in_ready, out_valid, out_tag, out_taken, out_next_pc, out_link,
             out_mispredict, out_misaligned
   );

   modport slave (
      input  in_valid, in_op, in_cmp, in_pc, in_rs1, in_rs2, in_imm,
             in_pred_taken, in_pred_target, in_tag, out_ready,
      output in_ready, out_valid, out_tag, out_taken, out_next_pc, out_link,
             out_mispredict, out_misaligned
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/JAL/JALR resolve unit.
//   S1 registers the issued op, S2 registers the resolved result.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : kill every in-flight op
//   bus (slave)         : issue handshake in, result handshake out
//   perf_branches       : resolved ops delivered
//   perf_mispredicts    : delivered ops that needed a redirect
// Compare encoding {unsigned_cmp, branch_cond}: cond 00 EQ, 01 NE, 10 LT, 11 GE;
// unsigned_cmp selects LTU/GEU and is ignored for EQ/NE.

module branch_compare #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            unsigned_i,
   input  logic [1:0]      cond_i,
   output logic            taken_o
);
   logic lt;

   assign lt = unsigned_i ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));

   always_comb begin
      case (cond_i)
         2'b00:   taken_o = (a_i == b_i);
         2'b01:   taken_o = (a_i != b_i);
         2'b10:   taken_o = lt;
         default: taken_o = !lt;
      endcase
   end
endmodule

module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   branch_resolve_unit_if.slave bus,
   output logic [31:0]          perf_branches,
   output logic [31:0]          perf_mispredicts
);
   localparam logic [1:0] OP_JAL  = 2'b01;
   localparam logic [1:0] OP_JALR = 2'b10;

   typedef struct packed {
      logic       unsigned_cmp;
      logic [1:0] branch_cond;
   } branch_compare_params_t;

   typedef struct packed {
      logic [1:0]             op;
      branch_compare_params_t cmp;
      logic [XLEN-1:0]        pc;
      logic [XLEN-1:0]        rs1;
      logic [XLEN-1:0]        rs2;
      logic [XLEN-1:0]        imm;
      logic                   pred_taken;
      logic [XLEN-1:0]        pred_target;
      logic [TAG_W-1:0]       tag;
   } s1_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             taken;
      logic [XLEN-1:0]  next_pc;
      logic [XLEN-1:0]  link;
      logic             mispredict;
      logic             misaligned;
   } s2_t;

   logic            s1_valid_q, s1_valid_d;
   logic            s2_valid_q, s2_valid_d;
   s1_t             s1_q, s1_d;
   s2_t             s2_q, s2_d, s2_eval;
   logic [31:0]     perf_br_q, perf_br_d;
   logic [31:0]     perf_mp_q, perf_mp_d;
   logic            s1_advance, in_ready, out_fire, cmp_taken;
   logic [XLEN-1:0] tgt_sum, target;

   assign s1_advance = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign in_ready   = !s1_valid_q || s1_advance;
   // A result handshaked on a flush cycle is delivered but not counted.
   assign out_fire   = s2_valid_q && bus.out_ready && !flush;

   branch_compare #(.XLEN(XLEN)) u_cmp (
      .a_i        (s1_q.rs1),
      .b_i        (s1_q.rs2),
      .unsigned_i (s1_q.cmp.unsigned_cmp),
      .cond_i     (s1_q.cmp.branch_cond),
      .taken_o    (cmp_taken)
   );

   // Resolve the op sitting in S1.
   always_comb begin
      s2_eval = '0;
      s2_eval.tag   = s1_q.tag;
      // Reserved op code resolves like a conditional branch.
      s2_eval.taken = (s1_q.op == OP_JAL) || (s1_q.op == OP_JALR) || cmp_taken;
      tgt_sum = ((s1_q.op == OP_JALR) ? s1_q.rs1 : s1_q.pc) + s1_q.imm;
      target  = tgt_sum;
      if (s1_q.op == OP_JALR) target[0] = 1'b0;
      s2_eval.link       = s1_q.pc + XLEN'(4);
      s2_eval.next_pc    = s2_eval.taken ? target : s2_eval.link;
      s2_eval.misaligned = s2_eval.taken && target[1];
      // A misaligned target traps instead of redirecting.
      s2_eval.mispredict = !s2_eval.misaligned &&
                           ((s2_eval.taken != s1_q.pred_taken) ||
                            (s2_eval.taken && (target != s1_q.pred_target)));
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      perf_br_d  = perf_br_q;
      perf_mp_d  = perf_mp_q;

      if (in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d.op                   = bus.in_op;
            s1_d.cmp.unsigned_cmp     = bus.in_cmp[2];
            s1_d.cmp.branch_cond      = bus.in_cmp[1:0];
            s1_d.pc                   = bus.in_pc;
            s1_d.rs1                  = bus.in_rs1;
            s1_d.rs2                  = bus.in_rs2;
            s1_d.imm                  = bus.in_imm;
            s1_d.pred_taken           = bus.in_pred_taken;
            s1_d.pred_target          = bus.in_pred_target;
            s1_d.tag                  = bus.in_tag;
         end
      end

      // S2 is free when empty or draining this cycle; it then takes whatever S1 holds.
      if (!s2_valid_q || bus.out_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) s2_d = s2_eval;
      end

      if (out_fire) begin
         perf_br_d = perf_br_q + 32'd1;
         if (s2_q.mispredict) perf_mp_d = perf_mp_q + 32'd1;
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         perf_br_q  <= '0;
         perf_mp_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         perf_br_q  <= perf_br_d;
         perf_mp_q  <= perf_mp_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = s2_valid_q;
   assign bus.out_tag        = s2_q.tag;
   assign bus.out_taken      = s2_q.taken;
   assign bus.out_next_pc    = s2_q.next_pc;
   assign bus.out_link       = s2_q.link;
   assign bus.out_mispredict = s2_q.mispredict;
   assign bus.out_misaligned = s2_q.misaligned;
   assign perf_branches      = perf_br_q;
   assign perf_mispredicts   = perf_mp_q;
endmodule
